// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader and its RAM.
package loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LEN_H = 3'd1,
    LDR_LEN_L = 3'd2,
    LDR_W_HI  = 3'd3,
    LDR_W_LO  = 3'd4,
    LDR_CSUM  = 3'd5,
    LDR_DONE  = 3'd6,
    LDR_ERR   = 3'd7
  } ldr_state_e;

  localparam logic [7:0] LDR_HEADER    = 8'hA5;
  localparam int         LDR_MAX_WORDS = 2048;

endpackage

// File: rtl/prog_loader_ram.sv
// prog_ram: program store for the fetch/execute core. One synchronous write
// port driven by the loader, one combinational read port driven by the
// core's MAR. A same-cycle write and read to one address returns the old word.
module prog_ram #(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 14
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];

  // Write port; contents are deliberately not reset so a reset mid-load
  // leaves earlier words in place.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a program image as a byte stream
// (A5, LEN_H, LEN_L, N x {HI, LO}, [CSUM]) and writes 14-bit words into
// prog_ram. cpu_rst holds the core in reset until an image loads cleanly.
// Build option: define LOADER_CSUM_EN to expect and verify a trailing
// checksum byte; without it the load completes on the last LO byte.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   LDR_IDLE  | waiting for header, other bytes dropped
//   LDR_LEN_H | expecting length high byte
//   LDR_LEN_L | expecting length low byte, length validated here
//   LDR_W_HI  | expecting word HI byte (bits 7:6 must be zero)
//   LDR_W_LO  | expecting word LO byte, word written to RAM
//   LDR_CSUM  | expecting checksum byte (LOADER_CSUM_EN only)
//   LDR_DONE  | image loaded, core released; header starts a reload
//   LDR_ERR   | last load failed; header starts a reload
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int WORD_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;

  ldr_state_e r_state;
  ldr_state_e w_state_nxt;
  logic              r_ready;
  logic [7:0]        r_len_h;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_waddr;
  logic [5:0]        r_hi;
`ifdef LOADER_CSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_accept;
  logic              w_we;
  logic              w_len_ok;
  logic              w_last;
  logic [15:0]       w_len_full;
  logic [ADDR_W:0]   w_waddr_inc;
  logic [WORD_W-1:0] w_wdata;

  assign w_accept    = in_valid & r_ready;
  assign w_len_full  = {r_len_h, in_byte};
  // Waddr counts words written; it is one bit wider than the RAM address
  // so that a full 2^ADDR_W-word image can reach its terminal count.
  assign w_len_ok    = (w_len_full != 16'd0) && (32'(w_len_full) <= 32'(DEPTH));
  assign w_waddr_inc = r_waddr + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last      = (w_waddr_inc == r_len);
  assign w_wdata     = WORD_W'({r_hi, in_byte});

  // State register and registered ready (low only in the reset cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LDR_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= 1'b1;
    end
  end

  // Next-state decode; every transition is qualified by a byte acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    if (w_accept) begin
      case (r_state)
        LDR_IDLE, LDR_DONE, LDR_ERR: begin
          if (in_byte == LDR_HEADER) w_state_nxt = LDR_LEN_H;
        end
        LDR_LEN_H: w_state_nxt = LDR_LEN_L;
        LDR_LEN_L: w_state_nxt = w_len_ok ? LDR_W_HI : LDR_ERR;
        LDR_W_HI:  w_state_nxt = (in_byte[7:6] != 2'b00) ? LDR_ERR : LDR_W_LO;
        LDR_W_LO: begin
          w_we = 1'b1;
`ifdef LOADER_CSUM_EN
          w_state_nxt = w_last ? LDR_CSUM : LDR_W_HI;
`else
          w_state_nxt = w_last ? LDR_DONE : LDR_W_HI;
`endif
        end
`ifdef LOADER_CSUM_EN
        LDR_CSUM:  w_state_nxt = (in_byte == r_csum) ? LDR_DONE : LDR_ERR;
`endif
        default:   w_state_nxt = LDR_IDLE;
      endcase
    end
  end

  // Length, write address, HI latch and running sum; all updated only on
  // accepted bytes so in_valid gaps have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_h <= 8'd0;
      r_len   <= '0;
      r_waddr <= '0;
      r_hi    <= 6'd0;
`ifdef LOADER_CSUM_EN
      r_csum  <= 8'd0;
`endif
    end else if (w_accept) begin
      case (r_state)
        LDR_LEN_H: r_len_h <= in_byte;
        LDR_LEN_L: begin
          if (w_len_ok) begin
            r_len   <= w_len_full[ADDR_W:0];
            r_waddr <= '0;
`ifdef LOADER_CSUM_EN
            r_csum  <= 8'd0;
`endif
          end
        end
        LDR_W_HI: begin
          r_hi <= in_byte[5:0];
`ifdef LOADER_CSUM_EN
          r_csum <= r_csum + in_byte;
`endif
        end
        LDR_W_LO: begin
          r_waddr <= w_waddr_inc;
`ifdef LOADER_CSUM_EN
          r_csum  <= r_csum + in_byte;
`endif
        end
        default: ;
      endcase
    end
  end

  prog_ram #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_prog_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_waddr[ADDR_W-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign in_ready = r_ready;
  assign done     = (r_state == LDR_DONE);
  assign err      = (r_state == LDR_ERR);
  assign cpu_rst  = (r_state != LDR_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected status/word
// values, a monitor pops and compares them on the falling edge.
module tb_prog_loader;

  localparam int ADDR_W = 11;
  localparam int WORD_W = 14;
`ifdef LOADER_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_byte;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              cpu_rst;
  logic              done;
  logic              err;

  prog_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_byte  (in_byte),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_word;
    logic [13:0] exp;
  } exp_t;

  typedef logic [7:0] bq_t[$];

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Monitor: status is packed as {in_ready, done, err, cpu_rst}.
  initial begin : monitor
    exp_t        e;
    logic [13:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = e.is_word ? rd_data : {10'd0, in_ready, done, err, cpu_rst};
        n_vec++;
        if (act !== e.exp) begin
          n_bad++;
          if (e.is_word)
            $display("FAIL %s: rd_data=%h expected %h", e.name, act, e.exp);
          else
            $display("FAIL %s: {rdy,done,err,cpu_rst}=%b expected %b",
                     e.name, act[3:0], e.exp[3:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_stat(input string nm, input bit rdy, input bit dn,
                           input bit er, input bit cr);
    exp_t e;
    e.name = nm; e.is_word = 1'b0; e.exp = {10'd0, rdy, dn, er, cr};
    sb_q.push_back(e);
  endtask

  task automatic push_word(input string nm, input logic [10:0] a,
                           input logic [13:0] v);
    exp_t e;
    rd_addr = a;
    e.name = nm; e.is_word = 1'b1; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic chk_stat(input string nm, input bit rdy, input bit dn,
                          input bit er, input bit cr);
    push_stat(nm, rdy, dn, er, cr);
    @(negedge clk); #1;
  endtask

  task automatic chk_word(input string nm, input logic [10:0] a,
                          input logic [13:0] v);
    push_word(nm, a, v);
    @(negedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    in_valid = 1'b0;
    repeat (gap) begin
      in_byte = 8'($urandom);
      @(posedge clk); #1;
    end
    in_byte  = b;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      n_vec++; n_bad++;
      $display("FAIL in_ready timeout: byte %h not accepted in 20 cycles", b);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input bq_t s, input int maxgap);
    foreach (s[i]) send_byte(s[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_stat({nm, " in reset"}, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_stat({nm, " after reset"}, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  bq_t good_s = '{8'hA5, 8'h00, 8'h03, 8'h3F, 8'h12, 8'h01, 8'h34, 8'h20, 8'h56, 8'hFC};
  bq_t badc_s = '{8'hA5, 8'h00, 8'h03, 8'h3F, 8'h12, 8'h01, 8'h34, 8'h20, 8'h56, 8'hFD};
  bq_t one_s  = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h07, 8'h07};
  bq_t part_s = '{8'hA5, 8'h00, 8'h03, 8'h3F, 8'h12, 8'h01, 8'h34};

  initial begin : stimulus
    logic [13:0] w;
    logic [7:0]  sum;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    rd_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    // Good load
    send_stream(good_s, 0);
    chk_stat("t1 done", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_word("t1 mem0", 11'd0, 14'h3F12);
    chk_word("t1 mem1", 11'd1, 14'h0134);
    chk_word("t1 mem2", 11'd2, 14'h2056);

    // Reload from DONE, overwriting from address 0
    send_byte(8'hA5, 0);
    chk_stat("t6 reload hdr", 1'b1, 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    push_word("t6 old word during write", 11'd0, 14'h3F12);
    send_byte(8'h07, 0);
    chk_word("t6 new mem0", 11'd0, 14'h0007);
    chk_word("t6 kept mem1", 11'd1, 14'h0134);
    send_byte(8'h07, 0);
    chk_stat("t6 done", 1'b1, 1'b1, 1'b0, 1'b0);

    // Bad checksum, then recovery with a correct stream
    send_stream(badc_s, 0);
    chk_stat("t2 bad csum", 1'b1, !CSUM, CSUM, CSUM);
    send_stream(good_s, 0);
    chk_stat("t2 recover", 1'b1, 1'b1, 1'b0, 1'b0);

    // Bad length / bad HI byte
    send_stream('{8'hA5, 8'h00, 8'h00}, 0);
    chk_stat("t3 len zero", 1'b1, 1'b0, 1'b1, 1'b1);
    send_stream('{8'h00, 8'h03, 8'h3F, 8'h12}, 0);
    chk_stat("t3 ignore after err", 1'b1, 1'b0, 1'b1, 1'b1);
    send_stream('{8'hA5, 8'h08}, 0);
    chk_stat("t3 len_h pending", 1'b1, 1'b0, 1'b0, 1'b1);
    send_byte(8'h01, 0);
    chk_stat("t3 len 2049", 1'b1, 1'b0, 1'b1, 1'b1);
    send_stream('{8'hA5, 8'h00, 8'h02}, 0);
    chk_stat("t3 len ok", 1'b1, 1'b0, 1'b0, 1'b1);
    send_byte(8'h40, 0);
    chk_stat("t3 hi 0x40", 1'b1, 1'b0, 1'b1, 1'b1);
    send_stream('{8'h12, 8'h34}, 0);
    chk_stat("t3 ignore after hi err", 1'b1, 1'b0, 1'b1, 1'b1);

    // Garbage and stalls from IDLE (mem0 first set to a different word)
    send_stream(one_s, 0);
    chk_word("t4 pre mem0", 11'd0, 14'h0007);
    do_reset("t4");
    send_stream('{8'h00, 8'hFF, 8'h7E}, 5);
    chk_stat("t4 garbage idle", 1'b1, 1'b0, 1'b0, 1'b1);
    send_stream(good_s, 5);
    chk_stat("t4 done", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_word("t4 mem0", 11'd0, 14'h3F12);
    chk_word("t4 mem1", 11'd1, 14'h0134);
    chk_word("t4 mem2", 11'd2, 14'h2056);

    // Reset mid-load after 2nd word
    send_stream(one_s, 0);
    chk_word("t5 pre mem0", 11'd0, 14'h0007);
    send_stream(part_s, 0);
    chk_stat("t5 mid load", 1'b1, 1'b0, 1'b0, 1'b1);
    do_reset("t5");
    chk_word("t5 retained mem0", 11'd0, 14'h3F12);
    send_stream(one_s, 0);
    chk_stat("t5 reload done", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_word("t5 reload mem0", 11'd0, 14'h0007);
    chk_word("t5 kept mem1", 11'd1, 14'h0134);

    // Maximum length image (2048 words)
    send_stream('{8'hA5, 8'h08, 8'h00}, 0);
    sum = 8'd0;
    for (int i = 0; i < 2048; i++) begin
      w = 14'(i * 5 + 3);
      send_byte({2'b00, w[13:8]}, 0);
      send_byte(w[7:0], 0);
      sum = sum + {2'b00, w[13:8]} + w[7:0];
    end
    if (CSUM) send_byte(sum, 0);
    chk_stat("max len done", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_word("max mem0", 11'd0, 14'd3);
    chk_word("max mem1024", 11'd1024, 14'(1024 * 5 + 3));
    chk_word("max mem2047", 11'd2047, 14'(2047 * 5 + 3));

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard drain: %0d left expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream feeder for the fetch/execute core: receives a program image as a byte stream over a valid/ready handshake and writes 14-bit instruction words into an internal 2048-word program RAM. The core's MAR drives `rd_addr` and its IR loads from `rd_data`, in place of a fixed ROM. `cpu_rst` holds the core in reset until an image has loaded and verified without error.

## Interface
- `ADDR_W`, 11: program address width; depth is 2^ADDR_W words.
- `WORD_W`, 14: instruction width; fixed at 14 by the byte format.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  loader accepts a byte. A byte is consumed on each edge where `in_valid && in_ready`.
- `in_byte`  in  8  stream byte.
- `rd_addr`  in  ADDR_W  fetch address from the core's MAR.
- `rd_data`  out  WORD_W  combinational read, `mem[rd_addr]`.
- `cpu_rst`  out  1  core reset request.
- `done`  out  1  image loaded and verified.
- `err`  out  1  last load attempt failed.

## Operation
- **Stream format:** header `0xA5`, then LEN_H, then LEN_L, then N words as HI,LO pairs, then CSUM.
  - N = {LEN_H, LEN_L}.
  - Each word is {HI[5:0], LO}.
  - CSUM is the 8-bit wrap-around sum of all HI and LO bytes. The header and length bytes are excluded.
- **FSM states:** IDLE, LEN_H, LEN_L, W_HI, W_LO, CSUM, DONE, ERR. Each transition occurs on a byte acceptance.
  - IDLE: on `0xA5` go to LEN_H. Any other byte is discarded and the FSM stays in IDLE.
  - LEN_H, then LEN_L: on the LEN_L byte, evaluate N. If N==0 or N>2^ADDR_W, go to ERR. Otherwise clear the write address and checksum, then go to W_HI.
  - W_HI: if byte[7:6]!=0, go to ERR. Otherwise latch the byte and go to W_LO.
  - W_LO: write {hi[5:0], byte} to `mem[waddr]` and increment `waddr`. When `waddr` reaches N, go to CSUM; otherwise go to W_HI.
  - CSUM: if the byte equals the running sum, go to DONE; otherwise go to ERR.
  - DONE and ERR: a `0xA5` byte starts a reload by going to LEN_H. Other bytes are discarded.
- **Outputs, decoded from state:**
  - `done` = (state==DONE).
  - `err` = (state==ERR).
  - `cpu_rst` = (state!=DONE).
- **Reset values:** state=IDLE, `in_ready`=0, `done`=0, `err`=0, `cpu_rst`=1, `waddr`=0, checksum=0. RAM contents are NOT cleared.
- `in_ready` is registered: 0 in the reset cycle, then 1 in every state thereafter.
- **Reset mid-load:** abandons the load. Words already written remain in RAM. The next load starts at address 0.

## Timing
- Byte acceptance to state change: 1 edge.
- Acceptance of the final byte (CSUM byte, or the last LO byte when the checksum is disabled): `done`=1 and `cpu_rst`=0 in the following cycle.
- Acceptance of a reload header in DONE: `cpu_rst`=1 and `done`=0 in the following cycle.
- RAM write: takes effect at the edge accepting LO. `rd_data` reflects the new word in the next cycle.
- `rd_data` is combinational from `rd_addr`, so the core's fetch timing is unchanged.
- A write and a read to the same address in the same cycle returns the old word.
- `in_valid` gaps of any length stall the FSM without side effects.

## Configuration
- `LOADER_CSUM_EN` defined: the CSUM state and running sum are present, as described above.
- `LOADER_CSUM_EN` undefined:
  - There is no CSUM byte and no sum register.
  - W_LO goes directly to DONE after word N.
  - A checksum mismatch is not a possible error.

## Structure
- `loader_pkg` contains:
  - the state enum `ldr_state_e`;
  - `LDR_HEADER` = 8'hA5;
  - `LDR_MAX_WORDS` = 2048.
- Sub-module `prog_ram`: single write port, combinational read port, parameterised by ADDR_W and WORD_W. It replaces `Program_Rom` at the core's fetch interface.

## Test plan
1. **Good load.** Stream A5 00 03 3F 12 01 34 20 56 FC. Required: `done`=1, `cpu_rst`=0, `err`=0. `rd_addr` 0/1/2 returns 14'h3F12 / 14'h0134 / 14'h2056.
2. **Bad checksum.** Same stream with a final byte of FD. Required: `err`=1, `done`=0, `cpu_rst`=1. A following correct stream gives `done`=1.
3. **Bad length or HI byte.** Each of the following gives `err`=1 at the offending byte, and later bytes are ignored until `0xA5`:
   - length 00 00;
   - length 08 01;
   - a HI byte of 0x40.
4. **Garbage and stalls.** Stream 00 FF 7E before the test 1 stream, with random `in_valid` gaps of 0-5 cycles. Required: identical result to test 1.
5. **Reset mid-load.** Assert `rst` after the 2nd word. Required: IDLE, `done`=0, `err`=0, `cpu_rst`=1, `in_ready`=0 for one cycle. `mem[0]`=14'h3F12 is retained. A reload of 1 word (A5 00 01 00 07 07) gives `mem[0]`=14'h0007.
6. **Reload from DONE.** Send A5 after test 1. Required: `cpu_rst`=1 in the next cycle. The new image overwrites from address 0.
